latch_en_arbiter: RTL and testbench

Sequencer and arbiter for a shared transparent-latch stage (gate `en`, data `a`). Up to `N_REQ` requesters compete to load data into the latch. The block grants one requester at a time, registers its data, and drives the latch gate with a non-overlapping setup/open/close sequence so D is stable for the whole time G is high. It sits directly above the latch hierarchy and owns its `en` and `a` inputs.

---
 rtl/latch_arb_pkg.sv | 36 +++
 rtl/latch_en_arbiter_if.sv | 42 ++++
 rtl/latch_arb_pick.sv | 60 ++++++
 rtl/latch_en_arbiter.sv | 157 +++++++++++++++
 tb/tb_latch_en_arbiter.sv | 173 +++++++++++++++++
 5 files changed

// File: rtl/latch_arb_pkg.sv
`default_nettype none
// ============================================================================
// Module      : latch_arb_pkg
// Description : Shared types and constants for the latch enable arbiter:
//               FSM state encoding, open-counter width, gate-length limits.
// Revision    : 1.0 - initial release
// ============================================================================
package latch_arb_pkg;

    // Sequencer states; 2-bit encoding
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SETUP = 2'd1,
        OPEN  = 2'd2,
        CLOSE = 2'd3
    } latch_arb_state_t;

    // Width of the gate-open down-counter
    localparam int LATCH_ARB_CW = 4;

    // Legal range of cycles the gate may be held open
    localparam int LATCH_ARB_OPEN_MIN = 1;
    localparam int LATCH_ARB_OPEN_MAX = 15;

    // Counter load value for a given open length, clamped into the legal
    // range so an out-of-range parameter can never wrap the counter.
    function automatic logic [LATCH_ARB_CW-1:0] latch_arb_open_load(input int open_cyc);
        int v_cyc;
        v_cyc = open_cyc;
        if (v_cyc < LATCH_ARB_OPEN_MIN) v_cyc = LATCH_ARB_OPEN_MIN;
        if (v_cyc > LATCH_ARB_OPEN_MAX) v_cyc = LATCH_ARB_OPEN_MAX;
        return LATCH_ARB_CW'(v_cyc - 1);
    endfunction

endpackage
`default_nettype wire

// File: rtl/latch_en_arbiter_if.sv
`default_nettype none
// ============================================================================
// Module      : latch_en_arbiter_if
// Description : Requester-side bundle of the latch enable arbiter: requests,
//               per-requester data, grants, done pulses and the latch drive.
// Revision    : 1.0 - initial release
// ============================================================================
interface latch_en_arbiter_if #(
    parameter int N_REQ = 4,
    parameter int DW    = 1
);
    logic [N_REQ-1:0]    i_req;
    logic [N_REQ*DW-1:0] i_a;
    logic [N_REQ-1:0]    o_gnt;
    logic [N_REQ-1:0]    o_done;
    logic                o_en;
    logic [DW-1:0]       o_a;
    logic                o_busy;

    // Requesters / environment side
    modport master (
        output i_req,
        output i_a,
        input  o_gnt,
        input  o_done,
        input  o_en,
        input  o_a,
        input  o_busy
    );

    // Arbiter side
    modport slave (
        input  i_req,
        input  i_a,
        output o_gnt,
        output o_done,
        output o_en,
        output o_a,
        output o_busy
    );
endinterface
`default_nettype wire

// File: rtl/latch_arb_pick.sv
`default_nettype none
// ============================================================================
// Module      : latch_arb_pick
// Description : Combinational winner selection for the latch enable arbiter.
//               LATCH_ARB_RR_EN defined   : round-robin search from i_ptr.
//               LATCH_ARB_RR_EN undefined : fixed priority, lowest index wins
//                                           (i_ptr is ignored).
// Revision    : 1.0 - initial release
// ============================================================================
module latch_arb_pick
    import latch_arb_pkg::*;
#(
    parameter int N_REQ = 4,
    parameter int PW    = 2
) (
    input  wire logic [N_REQ-1:0] i_req,
    input  wire logic [PW-1:0]    i_ptr,
    output logic      [N_REQ-1:0] o_win,
    output logic      [PW-1:0]    o_idx
);

`ifdef LATCH_ARB_RR_EN
    logic [PW-1:0] w_cand;
    logic          w_found;

    // Walk the requesters starting at the pointer; first set bit wins
    always_comb begin
        o_win   = '0;
        o_idx   = '0;
        w_cand  = '0;
        w_found = 1'b0;
        for (int i = 0; i < N_REQ; i++) begin
            w_cand = PW'((int'(i_ptr) + i) % N_REQ);
            if (!w_found && i_req[w_cand]) begin
                o_win[w_cand] = 1'b1;
                o_idx         = w_cand;
                w_found       = 1'b1;
            end
        end
    end
`else
    logic w_unused_ptr;
    assign w_unused_ptr = ^i_ptr;

    // Scan from the top down so the lowest set index is the last writer
    always_comb begin
        o_win = '0;
        o_idx = '0;
        for (int i = N_REQ - 1; i >= 0; i--) begin
            if (i_req[i]) begin
                o_win    = '0;
                o_win[i] = 1'b1;
                o_idx    = PW'(i);
            end
        end
    end
`endif

endmodule
`default_nettype wire

// File: rtl/latch_en_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : latch_en_arbiter
// Description : Arbitrates N_REQ requesters onto one transparent latch and
//               sequences its gate SETUP -> OPEN (OPEN_CYC cycles) -> CLOSE so
//               the registered data is stable whenever the gate is high.
//               Macro LATCH_ARB_RR_EN selects round-robin arbitration
//               (default: fixed priority, lowest index wins).
// Revision    : 1.0 - initial release
// ============================================================================
module latch_en_arbiter
    import latch_arb_pkg::*;
#(
    parameter int N_REQ    = 4,
    parameter int DW       = 1,
    parameter int OPEN_CYC = 2
) (
    input wire logic          i_clk,
    input wire logic          i_rst_n,
    latch_en_arbiter_if.slave bus
);

    localparam int c_PW = (N_REQ > 1) ? $clog2(N_REQ) : 1;
    localparam logic [LATCH_ARB_CW-1:0] c_OPEN_LOAD = latch_arb_open_load(OPEN_CYC);
    localparam logic [LATCH_ARB_CW-1:0] c_CNT_ONE   = LATCH_ARB_CW'(1);

    latch_arb_state_t        r_state_q, w_state_d;
    logic [LATCH_ARB_CW-1:0] r_cnt_q,   w_cnt_d;
    logic [N_REQ-1:0]        r_gnt_q,   w_gnt_d;
    logic [N_REQ-1:0]        r_done_q,  w_done_d;
    logic                    r_en_q,    w_en_d;
    logic [DW-1:0]           r_a_q,     w_a_d;

    logic [c_PW-1:0]         w_ptr;
    logic [N_REQ-1:0]        w_win;
    logic [c_PW-1:0]         w_win_idx;
    logic [DW-1:0]           w_win_data;
    logic                    w_any_req;

    assign w_any_req = |bus.i_req;

    latch_arb_pick #(
        .N_REQ (N_REQ),
        .PW    (c_PW)
    ) u_pick (
        .i_req (bus.i_req),
        .i_ptr (w_ptr),
        .o_win (w_win),
        .o_idx (w_win_idx)
    );

`ifdef LATCH_ARB_RR_EN
    localparam logic [c_PW-1:0] c_LAST_IDX = c_PW'(N_REQ - 1);

    logic [c_PW-1:0] r_ptr_q, w_ptr_d;

    assign w_ptr = r_ptr_q;

    // Advance the search start past the winner, only when a grant is issued
    always_comb begin
        w_ptr_d = r_ptr_q;
        if (r_state_q == IDLE && w_any_req) begin
            w_ptr_d = (w_win_idx == c_LAST_IDX) ? '0 : w_win_idx + c_PW'(1);
        end
    end

    // Round-robin pointer register
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_ptr_q <= '0;
        end else begin
            r_ptr_q <= w_ptr_d;
        end
    end
`else
    assign w_ptr = '0;
`endif

    // Winner's data slice; one-hot select keeps data of losers out entirely
    always_comb begin
        w_win_data = '0;
        for (int k = 0; k < N_REQ; k++) begin
            if (w_win[k]) begin
                w_win_data = bus.i_a[k*DW +: DW];
            end
        end
    end

    // Next-state and next-output logic; gate/done are decided one cycle
    // ahead so the outputs come straight from flops
    always_comb begin
        w_state_d = r_state_q;
        w_cnt_d   = r_cnt_q;
        w_gnt_d   = r_gnt_q;
        w_a_d     = r_a_q;
        w_en_d    = 1'b0;
        w_done_d  = '0;
        case (r_state_q)
            IDLE: begin
                if (w_any_req) begin
                    w_state_d = SETUP;
                    w_gnt_d   = w_win;
                    w_a_d     = w_win_data;
                end
            end
            SETUP: begin
                w_state_d = OPEN;
                w_cnt_d   = c_OPEN_LOAD;
                w_en_d    = 1'b1;
            end
            OPEN: begin
                if (r_cnt_q == '0) begin
                    w_state_d = CLOSE;
                    w_done_d  = r_gnt_q;
                end else begin
                    w_cnt_d = r_cnt_q - c_CNT_ONE;
                    w_en_d  = 1'b1;
                end
            end
            CLOSE: begin
                w_state_d = IDLE;
                w_gnt_d   = '0;
            end
            default: begin
                w_state_d = IDLE;
                w_gnt_d   = '0;
            end
        endcase
    end

    // State, counter and output registers with synchronous reset
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_state_q <= IDLE;
            r_cnt_q   <= '0;
            r_gnt_q   <= '0;
            r_done_q  <= '0;
            r_en_q    <= 1'b0;
            r_a_q     <= '0;
        end else begin
            r_state_q <= w_state_d;
            r_cnt_q   <= w_cnt_d;
            r_gnt_q   <= w_gnt_d;
            r_done_q  <= w_done_d;
            r_en_q    <= w_en_d;
            r_a_q     <= w_a_d;
        end
    end

    assign bus.o_gnt  = r_gnt_q;
    assign bus.o_done = r_done_q;
    assign bus.o_en   = r_en_q;
    assign bus.o_a    = r_a_q;
    assign bus.o_busy = (r_state_q != IDLE);

endmodule
`default_nettype wire

// File: tb/tb_latch_en_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_latch_en_arbiter
// Description : Self-checking bench: three arbiters (OPEN_CYC = 2, 1, 15)
//               share one stimulus stream and are compared every cycle with
//               a transaction-level model (grant cycle + phase offsets).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_latch_en_arbiter;

    localparam int N  = 4;
    localparam int DW = 2;
    localparam int ND = 3;

    logic           clk   = 1'b0;
    logic           rst_n = 1'b0;
    logic [N-1:0]   req   = '0;
    logic [N*DW-1:0] a    = '0;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;

    // Transaction model per DUT: arbitration cycle, winner, latched data, pointer
    bit            m_act  [ND];
    int            m_c0   [ND];
    int            m_w    [ND];
    logic [DW-1:0] m_data [ND];
    int            m_ptr  [ND];

    always #5 clk = ~clk;

    latch_en_arbiter_if #(.N_REQ(N), .DW(DW)) bus0 ();
    latch_en_arbiter_if #(.N_REQ(N), .DW(DW)) bus1 ();
    latch_en_arbiter_if #(.N_REQ(N), .DW(DW)) bus2 ();

    assign bus0.i_req = req;
    assign bus0.i_a   = a;
    assign bus1.i_req = req;
    assign bus1.i_a   = a;
    assign bus2.i_req = req;
    assign bus2.i_a   = a;

    latch_en_arbiter #(.N_REQ(N), .DW(DW), .OPEN_CYC(2))  u_dut0 (.i_clk(clk), .i_rst_n(rst_n), .bus(bus0));
    latch_en_arbiter #(.N_REQ(N), .DW(DW), .OPEN_CYC(1))  u_dut1 (.i_clk(clk), .i_rst_n(rst_n), .bus(bus1));
    latch_en_arbiter #(.N_REQ(N), .DW(DW), .OPEN_CYC(15)) u_dut2 (.i_clk(clk), .i_rst_n(rst_n), .bus(bus2));

    function automatic int oc(input int d);
        case (d)
            0:       return 2;
            1:       return 1;
            default: return 15;
        endcase
    endfunction

    // Winner by the arbitration rule in force
    function automatic int pick(input logic [N-1:0] r, input int ptr);
        int idx;
        idx = -1;
`ifdef LATCH_ARB_RR_EN
        for (int i = N - 1; i >= 0; i--) begin
            if (r[(ptr + i) % N]) idx = (ptr + i) % N;
        end
`else
        for (int i = N - 1; i >= 0; i--) begin
            if (r[i]) idx = i + 0 * ptr;
        end
`endif
        return idx;
    endfunction

    task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h cycle=%0d", tag, obs, exp, cyc);
        end
    endtask

    function automatic bit in_txn(input int d);
        int off;
        off = cyc - m_c0[d];
        return m_act[d] && off >= 1 && off <= oc(d) + 2;
    endfunction

    // One clock cycle: check this cycle's outputs, drive inputs, advance model
    task automatic step(input logic [N-1:0] r, input logic [N*DW-1:0] av, input logic rn);
        logic [7:0] o_gnt, o_done, o_en, o_a, o_busy;
        logic [7:0] e_gnt, e_done, e_en;
        int off;
        bit on;
        int w;
        @(negedge clk);
        for (int d = 0; d < ND; d++) begin
            case (d)
                0: begin o_gnt = 8'(bus0.o_gnt); o_done = 8'(bus0.o_done); o_en = 8'(bus0.o_en); o_a = 8'(bus0.o_a); o_busy = 8'(bus0.o_busy); end
                1: begin o_gnt = 8'(bus1.o_gnt); o_done = 8'(bus1.o_done); o_en = 8'(bus1.o_en); o_a = 8'(bus1.o_a); o_busy = 8'(bus1.o_busy); end
                default: begin o_gnt = 8'(bus2.o_gnt); o_done = 8'(bus2.o_done); o_en = 8'(bus2.o_en); o_a = 8'(bus2.o_a); o_busy = 8'(bus2.o_busy); end
            endcase
            off    = cyc - m_c0[d];
            on     = in_txn(d);
            e_gnt  = on ? 8'(1 << m_w[d]) : 8'h00;
            e_en   = (m_act[d] && off >= 2 && off <= oc(d) + 1) ? 8'h01 : 8'h00;
            e_done = (m_act[d] && off == oc(d) + 2) ? 8'(1 << m_w[d]) : 8'h00;
            check($sformatf("gnt[%0d]", d),  o_gnt,  e_gnt);
            check($sformatf("done[%0d]", d), o_done, e_done);
            check($sformatf("en[%0d]", d),   o_en,   e_en);
            check($sformatf("a[%0d]", d),    o_a,    8'(m_data[d]));
            check($sformatf("busy[%0d]", d), o_busy, on ? 8'h01 : 8'h00);
        end
        req   = r;
        a     = av;
        rst_n = rn;
        for (int d = 0; d < ND; d++) begin
            if (!rn) begin
                m_act[d]  = 1'b0;
                m_data[d] = '0;
                m_ptr[d]  = 0;
            end else if (!in_txn(d) && (|r)) begin
                w         = pick(r, m_ptr[d]);
                m_act[d]  = 1'b1;
                m_c0[d]   = cyc;
                m_w[d]    = w;
                m_data[d] = av[w*DW +: DW];
                m_ptr[d]  = (w + 1) % N;
            end
        end
        @(posedge clk);
        cyc++;
    endtask

    initial begin
        for (int d = 0; d < ND; d++) begin
            m_act[d]  = 1'b0;
            m_c0[d]   = 0;
            m_w[d]    = 0;
            m_data[d] = '0;
            m_ptr[d]  = 0;
        end
        // Power-on reset
        rst_n = 1'b0;
        repeat (2) @(posedge clk);

        // Reset values observed while reset is still held, then released
        step('0, '0, 1'b0);
        repeat (2) step('0, '0, 1'b1);

        // Single request from requester 2 with data 01
        repeat (5) step(4'b0100, 8'b00_01_00_00, 1'b1);
        repeat (18) step('0, '0, 1'b1);

        // Full contention with data toggling every cycle
        repeat (40) step(4'b1111, N*DW'($urandom), 1'b1);
        repeat (18) step('0, '0, 1'b1);

        // Requester 1 drops after grant, mid-transaction
        repeat (3) step(4'b0010, N*DW'($urandom), 1'b1);
        repeat (18) step('0, N*DW'($urandom), 1'b1);

        // Reset pulse while the gate is open, then contention again
        repeat (3) step(4'b1000, 8'b11_00_00_00, 1'b1);
        step(4'b1000, 8'b11_00_00_00, 1'b0);
        repeat (12) step(4'b1111, N*DW'($urandom), 1'b1);

        // Random traffic with occasional resets
        repeat (600) step(N'($urandom & $urandom), N*DW'($urandom), ($urandom_range(0, 63) != 0));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
